fp16_window_accumulator: RTL and testbench
==========================================

FP16_WINDOW_ACCUMULATOR -- requirements
Module: fp16_window_accumulator

Interface
REQ-001 SHALL have parameter LOG2_WIN, default 2, giving the window size WIN = 2^LOG2_WIN elements per average (legal range 1..4).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of a partially accumulated window.
REQ-005 SHALL have port in_valid  input  1  in_data holds a valid FP16 element.
REQ-006 SHALL have port in_ready  output  1  the block can accept an element this cycle.
REQ-007 SHALL have port in_data  input  16  FP16 element (sign[15], exponent[14:10], mantissa[9:0]).
REQ-008 SHALL have port out_valid  output  1  out_data holds a window average.
REQ-009 SHALL have port out_ready  input  1  the consumer accepts out_data this cycle.
REQ-010 SHALL have port out_data  output  16  FP16 average of the last WIN accepted elements.
REQ-011 SHALL have port busy  output  1  high when a window is partially or fully accumulated but not yet delivered.

Function
REQ-012 SHALL use the following adder semantics, which are the team's FP16 adder rules:
- a zero operand passes the other operand through;
- equal magnitudes with opposite signs give 0x0000;
- truncating alignment and normalisation, with no rounding;
- a negative result exponent flushes to 0x0000;
- no denormal, Inf or NaN handling.
REQ-013 SHALL implement a three-state FSM: ACCUM, SCALE, OUTPUT.
REQ-014 In ACCUM: in_ready = 1, and an element is accepted when in_valid && in_ready.
REQ-015 On acceptance: acc <= add(acc, in_data) and cnt <= cnt + 1. acc is 16 bits; cnt is LOG2_WIN+1 bits.
REQ-016 When the WIN-th element is accepted, the FSM SHALL move to SCALE on the next edge.
REQ-017 In SCALE: in_ready = 0, and the FSM takes one cycle to compute res.
- If acc == 0x0000 or acc[14:10] <= LOG2_WIN, then res = 0x0000.
- Otherwise res = {acc[15], acc[14:10] - LOG2_WIN, acc[9:0]}.
REQ-018 After SCALE the FSM SHALL enter OUTPUT. In OUTPUT: out_valid = 1, in_ready = 0, and out_data = res, held stable until out_valid && out_ready.
REQ-019 On the output handshake: acc <= 0x0000, cnt <= 0, and the FSM returns to ACCUM; in_ready rises the following cycle.
REQ-020 Latency: the WIN-th element is accepted at edge t; out_valid is high from edge t+2. Minimum period is WIN+2 cycles per window.
REQ-021 flush in ACCUM: acc <= 0 and cnt <= 0. If in_valid is also asserted, the element is discarded: it is not counted or summed, but in_ready still reads 1.
REQ-022 flush SHALL have no effect in SCALE or OUTPUT; a completed window is always delivered.
REQ-023 in_valid SHALL be ignored while in_ready = 0, with no state change.
REQ-024 busy = (cnt != 0) || state != ACCUM.
REQ-025 out_data SHALL be 0x0000 whenever out_valid = 0.
REQ-026 SHALL be purely synchronous: no combinational path from in_valid or in_data to the outputs. in_ready SHALL depend only on state.

Reset
REQ-027 While rst_n = 0 at an edge, the block SHALL set state = ACCUM, acc = 0x0000, cnt = 0.
REQ-028 Reset outputs: out_valid = 0, out_data = 0x0000, busy = 0, in_ready = 1 from the first edge after rst_n rises.
REQ-029 Reset asserted mid-window or in OUTPUT SHALL discard all partial or pending results. No output is produced for the aborted window.
REQ-030 rst_n SHALL take priority over flush and over every handshake.

Verification (LOG2_WIN = 2)
REQ-031 Ascending window:
- Stimulus: 0x3C00, 0x4000, 0x4200, 0x4400 on consecutive cycles, out_ready = 1.
- Response: out_valid for one cycle at t+2 with out_data = 0x4100 (2.5); in_ready is 0 for exactly 2 cycles.
REQ-032 Minimum-normal window:
- Stimulus: four elements of 0x0400.
- Response: out_data = 0x0400.
REQ-033 Underflow window:
- Stimulus: 0x0400 followed by three elements of 0x0000.
- Response: sum exponent is 1 (<= 2), so out_data = 0x0000.
REQ-034 Cancellation window:
- Stimulus: 0x3C00, 0xBC00, 0x4000, 0xC000.
- Response: out_data = 0x0000.
REQ-035 Backpressure:
- Stimulus: four elements of 0x3C00, with out_ready held 0 for 3 cycles after out_valid rises.
- Response: out_data = 0x3C00 stable throughout; in_ready = 0 and in_valid ignored until the handshake; the next window then accumulates from zero.
REQ-036 Abort cases:
- Stimulus: 0x4000 and 0x4000 accepted, then flush pulsed with in_valid = 1 and in_data = 0x4400, then four elements of 0x3C00.
- Response: the single output is 0x3C00.
- Repeat with rst_n low for one cycle instead of flush: identical result, and busy = 0 after reset.

Source files
------------

// File: rtl/fp16_window_accumulator.sv
// Averages every WIN = 2^LOG2_WIN accepted FP16 elements using the truncating team adder.
// Latency: out_valid two edges after the last element's edge; in_ready is low while scaling/outputting.
module fp16_window_accumulator #(
  parameter int LOG2_WIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {ACCUM, SCALE, OUTPUT} state_t;

  localparam logic [LOG2_WIN:0] CNT_LAST = {1'b0, {LOG2_WIN{1'b1}}};
  localparam logic [4:0]        EXP_SHIFT = 5'(LOG2_WIN);

  state_t            state, state_nxt;
  logic [15:0]       acc, res, acc_sum;
  logic [LOG2_WIN:0] cnt;
  logic              accept;

  // Truncating FP16 add: no rounding, no denormal/Inf/NaN, underflow flushes to zero.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml, r;
    logic [10:0] mb, ms, dif;
    logic [11:0] sum;
    logic [4:0]  ediff;
    logic [3:0]  lz;
    big = a; sml = b; r = 16'h0000;
    mb = '0; ms = '0; dif = '0; sum = '0; ediff = '0; lz = '0;
    if (a[14:0] == 15'd0) begin
      r = b;
    end else if (b[14:0] == 15'd0) begin
      r = a;
    end else if (a[14:0] == b[14:0] && a[15] != b[15]) begin
      r = 16'h0000;
    end else begin
      if (a[14:0] < b[14:0]) begin
        big = b;
        sml = a;
      end
      mb    = {1'b1, big[9:0]};
      ediff = big[14:10] - sml[14:10];
      ms    = {1'b1, sml[9:0]} >> ediff;
      if (big[15] == sml[15]) begin
        sum = {1'b0, mb} + {1'b0, ms};
        if (sum[11]) r = {big[15], big[14:10] + 5'd1, sum[10:1]};
        else         r = {big[15], big[14:10], sum[9:0]};
      end else begin
        dif = mb - ms;
        // Ascending scan so the highest set bit sets the final shift.
        for (int i = 0; i <= 10; i++) begin
          if (dif[i]) lz = 4'(10 - i);
        end
        if ({1'b0, big[14:10]} < {2'b00, lz}) begin
          r = 16'h0000;
        end else begin
          dif = dif << lz;
          r   = {big[15], big[14:10] - {1'b0, lz}, dif[9:0]};
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    acc_sum   = fp_add(acc, in_data);
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid && !flush;
        if (accept && cnt == CNT_LAST) state_nxt = SCALE;
      end
      SCALE:  state_nxt = OUTPUT;
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= 16'h0000;
      cnt   <= '0;
      res   <= 16'h0000;
    end else begin
      state <= state_nxt;
      case (state)
        ACCUM: begin
          if (flush) begin
            acc <= 16'h0000;
            cnt <= '0;
          end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
          end
        end
        SCALE: begin
          if (acc == 16'h0000 || acc[14:10] <= EXP_SHIFT) res <= 16'h0000;
          else res <= {acc[15], acc[14:10] - EXP_SHIFT, acc[9:0]};
        end
        OUTPUT: begin
          if (out_ready) begin
            acc <= 16'h0000;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_valid ? res : 16'h0000;
  assign busy     = (cnt != '0) || (state != ACCUM);

endmodule

// File: tb/tb_fp16_window_accumulator.sv
// Directed bench for fp16_window_accumulator with LOG2_WIN = 2 and hand-computed averages.
module tb_fp16_window_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data, out_data;

  int n_checks = 0;
  int n_pass   = 0;

  fp16_window_accumulator #(.LOG2_WIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 16'h0000;
  endtask

  // Four back-to-back elements, out_ready = 1; checks the two in_ready-low cycles and the result.
  task automatic window(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d,
                        input logic [15:0] exp, input logic flush_late);
    feed(a); feed(b); feed(c); feed(d);
    flush = flush_late;
    check({tag, " scale out_valid"}, {15'd0, out_valid}, 16'd0);
    check({tag, " scale in_ready"},  {15'd0, in_ready},  16'd0);
    tick();
    check({tag, " out_valid"}, {15'd0, out_valid}, 16'd1);
    check({tag, " in_ready low"}, {15'd0, in_ready}, 16'd0);
    check({tag, " out_data"}, out_data, exp);
    tick();
    flush = 1'b0;
    check({tag, " done out_valid"}, {15'd0, out_valid}, 16'd0);
    check({tag, " done in_ready"},  {15'd0, in_ready},  16'd1);
    check({tag, " done out_data"},  out_data, 16'h0000);
    check({tag, " done busy"},      {15'd0, busy}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset in_ready",  {15'd0, in_ready},  16'd1);
    check("reset out_valid", {15'd0, out_valid}, 16'd0);
    check("reset out_data",  out_data, 16'h0000);
    check("reset busy",      {15'd0, busy}, 16'd0);

    window("ascend",  16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4100, 1'b0);
    window("minnorm", 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 1'b0);
    window("uflow",   16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    window("cancel",  16'h3C00, 16'hBC00, 16'h4000, 16'hC000, 16'h0000, 1'b0);
    window("lateflush", 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1);

    // Backpressure: result held, new elements ignored until the handshake.
    out_ready = 1'b0;
    feed(16'h3C00); feed(16'h3C00); feed(16'h3C00); feed(16'h3C00);
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h4400;
      check("bp out_valid", {15'd0, out_valid}, 16'd1);
      check("bp out_data",  out_data, 16'h3C00);
      check("bp in_ready",  {15'd0, in_ready}, 16'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp hs out_data", out_data, 16'h3C00);
    tick();
    check("bp after busy", {15'd0, busy}, 16'd0);
    window("bp next", 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 1'b0);

    // Flush discards the partial window and the element presented with it.
    feed(16'h4000); feed(16'h4000);
    check("pre-flush busy", {15'd0, busy}, 16'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h4400;
    check("flush in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("post-flush busy", {15'd0, busy}, 16'd0);
    window("after flush", 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 1'b0);

    // Same abort via reset, which also outranks a pending element.
    feed(16'h4000); feed(16'h4000);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h4400;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    check("rst abort busy",     {15'd0, busy}, 16'd0);
    check("rst abort in_ready", {15'd0, in_ready}, 16'd1);
    window("after rst", 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 1'b0);

    // Reset while the result is pending drops it.
    out_ready = 1'b0;
    feed(16'h4000); feed(16'h4000); feed(16'h4000); feed(16'h4000);
    tick();
    check("pending out_valid", {15'd0, out_valid}, 16'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    check("rst out out_valid", {15'd0, out_valid}, 16'd0);
    check("rst out out_data",  out_data, 16'h0000);
    check("rst out busy",      {15'd0, busy}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
